fetch_seq: RTL and testbench
============================

FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 SHALL have port clk_i, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n_i, input, 1: reset, synchronous, active-low.
REQ-003 SHALL have port run_i, input, 1: enables starting a new fetch.
REQ-004 SHALL have ports mem_addr_o (output, 4), mem_rd_o (output, 1), mem_wr_o (output, 1) and mem_rdy_i (input, 1): memory request, read/write strobes and completion.
REQ-005 SHALL have port mem_rdata_i, input, 8: memory read data; instruction format is op[7:4], arg[3:0].
REQ-006 SHALL have ports op_o (output, 4) and arg_o (output, 4): latched instruction register fields; op_o drives the decoder.
REQ-007 SHALL have ports imm_i, jmp_i, mr_i, mw_i, inp_i, out_i and alu_i, each input, 1: decoded class flags returned by the decoder.
REQ-008 SHALL have port take_i, input, 1: branch condition from datapath (carry for BRC, zero for BRZ).
REQ-009 SHALL have ports in_vld_i (input, 1) and in_ack_o (output, 1): input-device handshake.
REQ-010 SHALL have ports out_vld_o (output, 1) and out_rdy_i (input, 1): output-device handshake.
REQ-011 SHALL have ports pc_o (output, 4), acc_ld_o (output, 1) and retire_o (output, 1): program counter, accumulator load strobe and one-cycle instruction-complete pulse.

Function
REQ-012 SHALL implement states FETCH, DECODE, READ, EXEC, WRITE, IN, OUT.
REQ-013 FETCH: when run_i=1, SHALL drive mem_rd_o=1 and mem_addr_o=pc_o; when run_i=0, mem_rd_o=0 and the state holds.
REQ-014 FETCH: on mem_rdy_i=1, SHALL latch mem_rdata_i into op/arg, set pc=pc+1 (15 wraps to 0) and go to DECODE.
REQ-015 DECODE: SHALL apply first-match priority jmp, inp, out, mr, alu, mw, imm, none.
REQ-016 DECODE, jmp_i=1: if take_i=1 or op=4'b0111, SHALL set pc=arg; SHALL pulse retire_o; next state is FETCH.
REQ-017 DECODE: inp_i SHALL select IN; out_i SHALL select OUT; mr_i SHALL select READ; alu_i or imm_i SHALL select EXEC; mw_i alone SHALL select WRITE.
REQ-018 DECODE with no flag set (NOP) SHALL pulse retire_o and return to FETCH.
REQ-019 READ: SHALL drive mem_rd_o=1 and mem_addr_o=arg; on mem_rdy_i, SHALL pulse acc_ld_o and retire_o in that same cycle, then go to FETCH.
REQ-020 EXEC: SHALL pulse acc_ld_o and retire_o for exactly one cycle, then go to FETCH.
REQ-021 WRITE: SHALL drive mem_wr_o=1 and mem_addr_o=arg until mem_rdy_i; SHALL pulse retire_o on completion; next state is FETCH.
REQ-022 IN: SHALL wait for in_vld_i; in the in_vld_i cycle, SHALL pulse in_ack_o, acc_ld_o and retire_o, then go to FETCH.
REQ-023 OUT: SHALL hold out_vld_o=1 until out_rdy_i=1; the transfer cycle SHALL pulse retire_o, and out_vld_o SHALL drop the next cycle.
REQ-024 Request strobes SHALL remain stable while waiting for mem_rdy_i; mem_rd_o and mem_wr_o SHALL never be asserted together.
REQ-025 run_i=0 mid-instruction SHALL NOT abort the instruction; it SHALL only block the next FETCH request.
REQ-026 Zero-wait latency SHALL be: NOP/branch/EXEC 2 or 3 cycles, LDA/ALU-memory 3 cycles, STA 3 cycles.
REQ-027 mem_rdy_i asserted outside FETCH/READ/WRITE SHALL be ignored.

Reset
REQ-028 On rst_n_i=0 at a clock edge, SHALL set state=FETCH and pc=0, op=0, arg=0.
REQ-029 During reset, SHALL drive all strobes (mem_rd_o, mem_wr_o, acc_ld_o, in_ack_o, out_vld_o, retire_o) to 0.
REQ-030 Reset asserted mid-transaction SHALL abandon the transaction with no retire_o.

Structure
REQ-031 Package angstrom_pkg SHALL hold the opcode constants (4'b0000-4'b1111), state enum, and data/address widths (8/4).
REQ-032 A single sub-module pc_reg (load, increment, wrap) SHALL be used.

Verification
REQ-033 Reset, then run_i=1, mem word 0x15 at addr 0, zero-wait -> op_o=1, arg_o=5, pc_o=1, acc_ld_o pulse at cycle 3.
REQ-034 BRZ (0x6A) with take_i=0 -> pc_o=1. Same with take_i=1 -> pc_o=10. JMP 0x7F at pc=15 -> pc_o=15. NOP at pc 15 -> pc_o=0 (wrap).
REQ-035 STA 0x23 with mem_rdy_i low 3 cycles -> mem_wr_o and mem_addr_o=3 stable 4 cycles, exactly one retire_o.
REQ-036 OUT with out_rdy_i delayed 5 cycles -> out_vld_o high 6 cycles, retire_o on the transfer cycle; INP with in_vld_i at cycle 2 -> in_ack_o and acc_ld_o coincide.
REQ-037 rst_n_i low during READ wait -> next cycle state FETCH, pc_o=0, no acc_ld_o/retire_o; run_i=0 after DECODE -> current instruction retires, no further mem_rd_o.

Source files
------------

// File: rtl/angstrom_pkg.sv
// rtl/angstrom_pkg.sv - shared widths, opcodes and sequencer states
package angstrom_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_STA = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_BRC = 4'b0101;
  localparam logic [3:0] OP_BRZ = 4'b0110;
  localparam logic [3:0] OP_JMP = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1000;
  localparam logic [3:0] OP_AND = 4'b1001;
  localparam logic [3:0] OP_OR  = 4'b1010;
  localparam logic [3:0] OP_XOR = 4'b1011;
  localparam logic [3:0] OP_INP = 4'b1100;
  localparam logic [3:0] OP_OUT = 4'b1101;
  localparam logic [3:0] OP_SHL = 4'b1110;
  localparam logic [3:0] OP_SHR = 4'b1111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_READ   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_IN     = 3'd5,
    ST_OUT    = 3'd6
  } st_e;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter with load, increment and natural wrap
module pc_reg
  import angstrom_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ld_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] ld_val_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  // Load wins over increment; the two never coincide in the sequencer anyway.
  always_comb begin
    pc_d = pc_q;
    if (ld_i)       pc_d = ld_val_i;
    else if (inc_i) pc_d = pc_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) pc_q <= '0;
    else          pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - instruction fetch/execute sequencer for the angstrom core
module fetch_seq
  import angstrom_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              run_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  input  logic              mem_rdy_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [3:0]        op_o,
  output logic [3:0]        arg_o,
  input  logic              imm_i,
  input  logic              jmp_i,
  input  logic              mr_i,
  input  logic              mw_i,
  input  logic              inp_i,
  input  logic              out_i,
  input  logic              alu_i,
  input  logic              take_i,
  input  logic              in_vld_i,
  output logic              in_ack_o,
  output logic              out_vld_o,
  input  logic              out_rdy_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              acc_ld_o,
  output logic              retire_o
);

  st_e        state_q, state_d;
  logic [3:0] op_q, arg_q;
  logic       ir_ld, pc_ld, no_flag;

  assign ir_ld   = (state_q == ST_FETCH) && run_i && mem_rdy_i;
  assign pc_ld   = (state_q == ST_DECODE) && jmp_i && (take_i || (op_q == OP_JMP));
  assign no_flag = !(jmp_i || inp_i || out_i || mr_i || alu_i || mw_i || imm_i);

  pc_reg u_pc (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .ld_i     (pc_ld),
    .inc_i    (ir_ld),
    .ld_val_i (arg_q),
    .pc_o     (pc_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      arg_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ir_ld) begin
        op_q  <= mem_rdata_i[7:4];
        arg_q <= mem_rdata_i[3:0];
      end
    end
  end

  // Decode order encodes the flag priority: jmp, inp, out, mr, alu, mw, imm.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (ir_ld) state_d = ST_DECODE;
      ST_DECODE: begin
        if (jmp_i)              state_d = ST_FETCH;
        else if (inp_i)         state_d = ST_IN;
        else if (out_i)         state_d = ST_OUT;
        else if (mr_i)          state_d = ST_READ;
        else if (alu_i)         state_d = ST_EXEC;
        else if (mw_i)          state_d = ST_WRITE;
        else if (imm_i)         state_d = ST_EXEC;
        else                    state_d = ST_FETCH;
      end
      ST_READ:   if (mem_rdy_i) state_d = ST_FETCH;
      ST_EXEC:                  state_d = ST_FETCH;
      ST_WRITE:  if (mem_rdy_i) state_d = ST_FETCH;
      ST_IN:     if (in_vld_i)  state_d = ST_FETCH;
      ST_OUT:    if (out_rdy_i) state_d = ST_FETCH;
      default:                  state_d = ST_FETCH;
    endcase
  end

  // Strobes are gated by reset so a stale state cannot leak during the reset cycle.
  always_comb begin
    mem_addr_o = pc_o;
    mem_rd_o   = 1'b0;
    mem_wr_o   = 1'b0;
    acc_ld_o   = 1'b0;
    in_ack_o   = 1'b0;
    out_vld_o  = 1'b0;
    retire_o   = 1'b0;
    if (rst_n_i) begin
      case (state_q)
        ST_FETCH:  mem_rd_o = run_i;
        ST_DECODE: retire_o = jmp_i || no_flag;
        ST_READ: begin
          mem_rd_o   = 1'b1;
          mem_addr_o = arg_q;
          acc_ld_o   = mem_rdy_i;
          retire_o   = mem_rdy_i;
        end
        ST_EXEC: begin
          acc_ld_o = 1'b1;
          retire_o = 1'b1;
        end
        ST_WRITE: begin
          mem_wr_o   = 1'b1;
          mem_addr_o = arg_q;
          retire_o   = mem_rdy_i;
        end
        ST_IN: begin
          in_ack_o = in_vld_i;
          acc_ld_o = in_vld_i;
          retire_o = in_vld_i;
        end
        ST_OUT: begin
          out_vld_o = 1'b1;
          retire_o  = out_rdy_i;
        end
        default: ;
      endcase
    end
  end

  assign op_o  = op_q;
  assign arg_o = arg_q;

endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - directed self-checking bench for fetch_seq
module tb_fetch_seq;

  logic       clk = 1'b0;
  logic       rst_n, run, rdy, take, in_vld, out_rdy;
  logic [3:0] mem_addr, op, arg, pc;
  logic       mem_rd, mem_wr, in_ack, out_vld, acc_ld, retire;
  logic       imm, jmp, mr, mw, inp, outf, alu;
  logic [7:0] mem [16];
  logic [7:0] rdata;
  int         checks = 0;
  int         errors = 0;
  int         retire_cnt = 0;
  int         cnt0;

  always #5 clk = ~clk;

  assign rdata = mem[mem_addr];

  always_comb begin
    mr   = (op == 4'h1);
    mw   = (op == 4'h2);
    alu  = (op == 4'h3);
    jmp  = (op == 4'h5) || (op == 4'h6) || (op == 4'h7);
    imm  = (op == 4'h8);
    inp  = (op == 4'hC);
    outf = (op == 4'hD);
  end

  always @(posedge clk) if (retire) retire_cnt <= retire_cnt + 1;

  fetch_seq dut (
    .clk_i(clk), .rst_n_i(rst_n), .run_i(run),
    .mem_addr_o(mem_addr), .mem_rd_o(mem_rd), .mem_wr_o(mem_wr),
    .mem_rdy_i(rdy), .mem_rdata_i(rdata),
    .op_o(op), .arg_o(arg),
    .imm_i(imm), .jmp_i(jmp), .mr_i(mr), .mw_i(mw), .inp_i(inp), .out_i(outf), .alu_i(alu),
    .take_i(take), .in_vld_i(in_vld), .in_ack_o(in_ack),
    .out_vld_o(out_vld), .out_rdy_i(out_rdy),
    .pc_o(pc), .acc_ld_o(acc_ld), .retire_o(retire)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    run   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rst_n = 1'b0; run = 1'b1; rdy = 1'b1; take = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    step();
    step();
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_retire", retire, 1'b0);
    chk("rst_acc_ld", acc_ld, 1'b0);
    chk("rst_pc", pc, 4'd0);
    chk("rst_op", op, 4'd0);
    chk("rst_arg", arg, 4'd0);

    // LDA 5 at address 0, zero-wait
    mem[0] = 8'h15;
    rst_n = 1'b1; #1;
    chk("lda_fetch_rd", mem_rd, 1'b1);
    chk("lda_fetch_addr", mem_addr, 4'd0);
    step();
    chk("lda_op", op, 4'd1);
    chk("lda_arg", arg, 4'd5);
    chk("lda_pc", pc, 4'd1);
    chk("lda_decode_rd", mem_rd, 1'b0);
    run = 1'b0;
    step();
    chk("lda_read_rd", mem_rd, 1'b1);
    chk("lda_read_addr", mem_addr, 4'd5);
    chk("lda_acc_ld_c3", acc_ld, 1'b1);
    chk("lda_retire_c3", retire, 1'b1);
    step();
    chk("stop_rd", mem_rd, 1'b0);
    chk("stop_acc", acc_ld, 1'b0);
    step();
    chk("stop_rd2", mem_rd, 1'b0);

    // BRZ not taken / taken
    mem[0] = 8'h6A;
    reset_dut(); run = 1'b1; take = 1'b0; #1;
    step();
    chk("brz_nt_retire", retire, 1'b1);
    run = 1'b0;
    step();
    chk("brz_nt_pc", pc, 4'd1);
    reset_dut(); run = 1'b1; take = 1'b1; #1;
    step();
    run = 1'b0;
    step();
    chk("brz_t_pc", pc, 4'd10);
    take = 1'b0;

    // JMP to 15, NOP at 15 wraps, then JMP at 15
    mem[0] = 8'h7F; mem[15] = 8'h00;
    reset_dut(); run = 1'b1; #1;
    step();
    step();
    chk("jmp_pc", pc, 4'd15);
    chk("jmp_fetch_addr", mem_addr, 4'd15);
    step();
    chk("nop_wrap_pc", pc, 4'd0);
    chk("nop_retire", retire, 1'b1);
    mem[15] = 8'h7F;
    step();
    step();
    step();
    step();
    chk("jmp15_decode_pc", pc, 4'd0);
    run = 1'b0;
    step();
    chk("jmp15_pc", pc, 4'd15);

    // STA 3 with three wait cycles
    mem[0] = 8'h23;
    reset_dut(); run = 1'b1; rdy = 1'b1; #1;
    step();
    rdy = 1'b0; run = 1'b0;
    step();
    cnt0 = retire_cnt;
    for (int i = 0; i < 3; i++) begin
      chk("sta_wait_wr", mem_wr, 1'b1);
      chk("sta_wait_addr", mem_addr, 4'd3);
      chk("sta_wait_rd", mem_rd, 1'b0);
      chk("sta_wait_retire", retire, 1'b0);
      step();
    end
    rdy = 1'b1; #1;
    chk("sta_done_wr", mem_wr, 1'b1);
    chk("sta_done_addr", mem_addr, 4'd3);
    chk("sta_done_retire", retire, 1'b1);
    step();
    chk("sta_after_wr", mem_wr, 1'b0);
    chk("sta_retire_count", retire_cnt - cnt0, 1);

    // ALU op through EXEC
    mem[0] = 8'h30;
    reset_dut(); run = 1'b1; #1;
    step();
    run = 1'b0;
    step();
    chk("exec_acc_ld", acc_ld, 1'b1);
    chk("exec_retire", retire, 1'b1);
    step();
    chk("exec_after_acc", acc_ld, 1'b0);

    // OUT with five-cycle stall
    mem[0] = 8'hD0;
    reset_dut(); run = 1'b1; #1;
    step();
    run = 1'b0; out_rdy = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("out_wait_vld", out_vld, 1'b1);
      chk("out_wait_retire", retire, 1'b0);
      step();
    end
    out_rdy = 1'b1; #1;
    chk("out_xfer_vld", out_vld, 1'b1);
    chk("out_xfer_retire", retire, 1'b1);
    step();
    out_rdy = 1'b0; #1;
    chk("out_drop_vld", out_vld, 1'b0);

    // INP with in_vld on second IN cycle
    mem[0] = 8'hC0;
    reset_dut(); run = 1'b1; #1;
    step();
    run = 1'b0; in_vld = 1'b0;
    step();
    chk("inp_wait_ack", in_ack, 1'b0);
    chk("inp_wait_acc", acc_ld, 1'b0);
    step();
    in_vld = 1'b1; #1;
    chk("inp_ack", in_ack, 1'b1);
    chk("inp_acc", acc_ld, 1'b1);
    chk("inp_retire", retire, 1'b1);
    step();
    in_vld = 1'b0; #1;
    chk("inp_after_ack", in_ack, 1'b0);

    // Reset during READ wait
    mem[0] = 8'h15;
    reset_dut(); run = 1'b1; rdy = 1'b1; #1;
    step();
    run = 1'b0; rdy = 1'b0;
    step();
    chk("rdw_rd", mem_rd, 1'b1);
    chk("rdw_acc", acc_ld, 1'b0);
    cnt0 = retire_cnt;
    rst_n = 1'b0; rdy = 1'b1; #1;
    chk("rdw_rst_acc", acc_ld, 1'b0);
    chk("rdw_rst_retire", retire, 1'b0);
    chk("rdw_rst_rd", mem_rd, 1'b0);
    step();
    rst_n = 1'b1; #1;
    chk("rdw_pc", pc, 4'd0);
    chk("rdw_op", op, 4'd0);
    chk("rdw_idle_rd", mem_rd, 1'b0);
    chk("rdw_no_retire", retire_cnt - cnt0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
